output_p4_interface: RTL and testbench
======================================

# output_p4_interface

Merges the four per-vSwitch AXI4-Stream outputs of the nf_sume_sdnet_ips instances into one stream towards the output queues. It uses packet-atomic round-robin arbitration and a single registered output stage. It is the egress counterpart of the VLAN-ID demultiplexer that feeds the four P4 instances.

## Interface
- C_M_AXIS_DATA_WIDTH, 256: master tdata width
- C_S_AXIS_DATA_WIDTH, 256: slave tdata width; must equal master width
- C_M_AXIS_TUSER_WIDTH, 128: master tuser width
- C_S_AXIS_TUSER_WIDTH, 128: slave tuser width; must equal master width
- NUM_INPUTS, 4: number of slave streams; fixed at 4
- axis_aclk  in  1  single clock for all logic
- axis_reset  in  1  synchronous, active-high reset
- s_axis_N_tdata, N=0..3  in  C_S_AXIS_DATA_WIDTH  per-vSwitch packet data
- s_axis_N_tkeep  in  C_S_AXIS_DATA_WIDTH/8  byte enables
- s_axis_N_tuser  in  C_S_AXIS_TUSER_WIDTH  SUME metadata (len[15:0], src[23:16], dst[31:24])
- s_axis_N_tvalid  in  1  beat valid
- s_axis_N_tlast  in  1  last beat of packet
- s_axis_N_tready  out  1  beat accepted when high with tvalid
- m_axis_tdata  out  C_M_AXIS_DATA_WIDTH  merged data
- m_axis_tkeep  out  C_M_AXIS_DATA_WIDTH/8  merged byte enables
- m_axis_tuser  out  C_M_AXIS_TUSER_WIDTH  merged metadata
- m_axis_tvalid  out  1  output beat valid
- m_axis_tlast  out  1  output last beat
- m_axis_tready  in  1  downstream ready

## Operation
- Two states.
  - IDLE: no packet in flight.
  - FWD: a packet from input `grant` is being forwarded.
- IDLE:
  - All s_axis_N_tready are 0.
  - If any s_axis_N_tvalid is high, select the first valid input searching upward from (last_grant+1) mod 4 and wrapping.
  - Load `grant`, go to FWD.
  - Candidates are sampled on tvalid only; tuser/tdata are not inspected.
- FWD:
  - s_axis_grant_tready = (~m_axis_tvalid | m_axis_tready). All other inputs keep tready 0.
  - An accepted beat loads the output register (tdata, tkeep, tuser, tlast) and sets m_axis_tvalid=1.
  - Acceptance of a beat with tlast=1: last_grant<=grant, go to IDLE.
  - A tvalid gap mid-packet holds FWD and the grant. Other inputs are never interleaved.
- Output register:
  - m_axis_tvalid clears when m_axis_tready=1 and no new beat is accepted in the same cycle.
  - Output fields hold while m_axis_tvalid=1 and m_axis_tready=0.
- Single-beat packets (first beat has tlast=1) are legal. They pass through FWD for exactly one accepted beat.
- No beats are dropped, duplicated or reordered within a packet.

## Timing
- Reset values:
  - m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata/tkeep/tuser=0.
  - All s_axis_N_tready=0.
  - State IDLE, last_grant=3, so input 0 has first priority.
- Latency: a beat accepted in cycle t appears on m_axis in cycle t+1.
- Arbitration costs one idle cycle per packet: IDLE to FWD takes one cycle, during which no slave tready is high.
- Throughput: one beat/cycle during a packet under continuous m_axis_tready.
- Simultaneous requests: the rotating pointer resolves them. With all four continuously valid, the grant order is 0,1,2,3,0,...
- Reset mid-packet:
  - Output register and state clear on the next edge.
  - The partial packet is abandoned. Downstream must tolerate the truncation, because the partial packet was never closed by tlast.

## Configuration
- OUTPUT_P4_SRC_STAMP_EN defined:
  - On the first beat of each packet, m_axis_tuser[33:32] is overwritten with the 2-bit grant index (the vSwitch ID).
  - Non-first beats pass unchanged.
  - A first-beat flag sets on entry to FWD and clears after the first accepted beat.
- Undefined: tuser passes bit-exact on every beat, and no first-beat flag exists.

## Structure
- Package output_p4_interface_pkg holds:
  - State encoding localparams (IDLE=0, FWD=1).
  - NUM_INPUTS=4 and GRANT_WIDTH=2.
  - SRC_STAMP_LSB=32.
- One sub-module, rr_arbiter4: a combinational round-robin pick from (req[3:0], last_grant) producing grant and any_req. The pointer register stays in the parent.

## Test plan
- Single 2-beat packet on input 2 (tuser=0x0040_0040, tlast on beat 1):
  - Output carries identical 2 beats.
  - First m_axis_tvalid appears 2 cycles after s_axis_2_tvalid rises.
  - Other inputs' tready stay 0.
- All four inputs present 3-beat packets simultaneously and continuously:
  - Output packet source order is 0,1,2,3,0.
  - No beat interleaving between packets.
  - Exactly one idle cycle between packets.
- Input 1 mid-packet drops tvalid for 5 cycles while input 3 is valid:
  - Input 3 is not granted until input 1's tlast is accepted.
- m_axis_tready held 0 for 4 cycles mid-packet:
  - m_axis fields are stable throughout.
  - s_axis_grant_tready=0 throughout.
  - Transfer resumes with no beat lost.
- axis_reset asserted for 1 cycle during beat 2 of a 4-beat packet:
  - Next cycle: m_axis_tvalid=0, all tready=0, state IDLE.
  - A subsequent request from input 0 wins over input 1.
- With OUTPUT_P4_SRC_STAMP_EN, 2-beat packet on input 3:
  - Beat 0 has tuser[33:32]=2'b11.
  - Beat 1 tuser is unchanged.
  - Without the macro, tuser is bit-exact on both beats.

Source files
------------

// File: rtl/output_p4_interface_pkg.sv
// Shared types and constants for the four-input P4 egress merger.
package output_p4_interface_pkg;

    localparam logic STATE_IDLE = 1'b0;
    localparam logic STATE_FWD  = 1'b1;

    typedef enum logic {
        IDLE = STATE_IDLE,
        FWD  = STATE_FWD
    } state_e;

    localparam int NUM_INPUTS    = 4;
    localparam int GRANT_WIDTH   = 2;
    localparam int SRC_STAMP_LSB = 32;

endpackage

// File: rtl/output_p4_interface_rr_arbiter4.sv
// Combinational round-robin pick among four requesters, starting one past last_grant.
module rr_arbiter4
    import output_p4_interface_pkg::*;
(
    input  logic [NUM_INPUTS-1:0]  req,
    input  logic [GRANT_WIDTH-1:0] last_grant,
    output logic [GRANT_WIDTH-1:0] grant,
    output logic                   any_req
);

    logic [GRANT_WIDTH-1:0] idx;

    // Walk from lowest to highest priority so the nearest requester overwrites last.
    always_comb begin
        idx     = '0;
        grant   = last_grant;
        any_req = |req;
        for (int i = NUM_INPUTS; i >= 1; i--) begin
            idx = last_grant + GRANT_WIDTH'(i);
            if (req[idx]) begin
                grant = idx;
            end
        end
    end

endmodule

// File: rtl/output_p4_interface.sv
// Packet-atomic round-robin merge of four AXI4-Stream inputs into one registered output.
// Optional OUTPUT_P4_SRC_STAMP_EN: first beat of each packet carries the grant index in tuser[33:32].
//   state | meaning
//   IDLE  | no packet in flight; arbitrate among valid inputs
//   FWD   | forwarding the packet from input grant_q until its tlast is accepted
module output_p4_interface
    import output_p4_interface_pkg::*;
#(
    parameter int C_M_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_M_AXIS_TUSER_WIDTH = 128,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int NUM_INPUTS           = 4
) (
    input  logic                                axis_aclk,
    input  logic                                axis_reset,

    input  logic [C_S_AXIS_DATA_WIDTH-1:0]      s_axis_0_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]    s_axis_0_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]     s_axis_0_tuser,
    input  logic                                s_axis_0_tvalid,
    input  logic                                s_axis_0_tlast,
    output logic                                s_axis_0_tready,

    input  logic [C_S_AXIS_DATA_WIDTH-1:0]      s_axis_1_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]    s_axis_1_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]     s_axis_1_tuser,
    input  logic                                s_axis_1_tvalid,
    input  logic                                s_axis_1_tlast,
    output logic                                s_axis_1_tready,

    input  logic [C_S_AXIS_DATA_WIDTH-1:0]      s_axis_2_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]    s_axis_2_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]     s_axis_2_tuser,
    input  logic                                s_axis_2_tvalid,
    input  logic                                s_axis_2_tlast,
    output logic                                s_axis_2_tready,

    input  logic [C_S_AXIS_DATA_WIDTH-1:0]      s_axis_3_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]    s_axis_3_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]     s_axis_3_tuser,
    input  logic                                s_axis_3_tvalid,
    input  logic                                s_axis_3_tlast,
    output logic                                s_axis_3_tready,

    output logic [C_M_AXIS_DATA_WIDTH-1:0]      m_axis_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]    m_axis_tkeep,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]     m_axis_tuser,
    output logic                                m_axis_tvalid,
    output logic                                m_axis_tlast,
    input  logic                                m_axis_tready
);

    logic [C_S_AXIS_DATA_WIDTH-1:0]   s_tdata [NUM_INPUTS];
    logic [C_S_AXIS_DATA_WIDTH/8-1:0] s_tkeep [NUM_INPUTS];
    logic [C_S_AXIS_TUSER_WIDTH-1:0]  s_tuser [NUM_INPUTS];
    logic [NUM_INPUTS-1:0]            s_tvalid;
    logic [NUM_INPUTS-1:0]            s_tlast;
    logic [NUM_INPUTS-1:0]            s_tready;

    assign s_tdata  = '{s_axis_0_tdata, s_axis_1_tdata, s_axis_2_tdata, s_axis_3_tdata};
    assign s_tkeep  = '{s_axis_0_tkeep, s_axis_1_tkeep, s_axis_2_tkeep, s_axis_3_tkeep};
    assign s_tuser  = '{s_axis_0_tuser, s_axis_1_tuser, s_axis_2_tuser, s_axis_3_tuser};
    assign s_tvalid = {s_axis_3_tvalid, s_axis_2_tvalid, s_axis_1_tvalid, s_axis_0_tvalid};
    assign s_tlast  = {s_axis_3_tlast, s_axis_2_tlast, s_axis_1_tlast, s_axis_0_tlast};

    assign s_axis_0_tready = s_tready[0];
    assign s_axis_1_tready = s_tready[1];
    assign s_axis_2_tready = s_tready[2];
    assign s_axis_3_tready = s_tready[3];

    state_e                           state_q, state_d;
    logic [GRANT_WIDTH-1:0]           grant_q, grant_d;
    logic [GRANT_WIDTH-1:0]           last_grant_q, last_grant_d;
    logic [C_M_AXIS_DATA_WIDTH-1:0]   tdata_q, tdata_d;
    logic [C_M_AXIS_DATA_WIDTH/8-1:0] tkeep_q, tkeep_d;
    logic [C_M_AXIS_TUSER_WIDTH-1:0]  tuser_q, tuser_d;
    logic                             tvalid_q, tvalid_d;
    logic                             tlast_q, tlast_d;
`ifdef OUTPUT_P4_SRC_STAMP_EN
    logic                             first_q, first_d;
`endif

    logic [GRANT_WIDTH-1:0] arb_grant;
    logic                   arb_any;
    logic                   slave_ready;
    logic                   accept;

    rr_arbiter4 u_arb (
        .req        (s_tvalid),
        .last_grant (last_grant_q),
        .grant      (arb_grant),
        .any_req    (arb_any)
    );

    // Output register may take a new beat when empty or draining this cycle.
    assign slave_ready = (state_q == FWD) && (!tvalid_q || m_axis_tready);
    assign accept      = slave_ready && s_tvalid[grant_q];
    assign s_tready    = slave_ready ? (NUM_INPUTS'(1) << grant_q) : '0;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        tdata_d      = tdata_q;
        tkeep_d      = tkeep_q;
        tuser_d      = tuser_q;
        tlast_d      = tlast_q;
        tvalid_d     = tvalid_q;
`ifdef OUTPUT_P4_SRC_STAMP_EN
        first_d      = first_q;
`endif
        if (tvalid_q && m_axis_tready) begin
            tvalid_d = 1'b0;
        end
        case (state_q)
            IDLE: begin
                if (arb_any) begin
                    grant_d = arb_grant;
                    state_d = FWD;
`ifdef OUTPUT_P4_SRC_STAMP_EN
                    first_d = 1'b1;
`endif
                end
            end
            FWD: begin
                if (accept) begin
                    tdata_d  = s_tdata[grant_q];
                    tkeep_d  = s_tkeep[grant_q];
                    tuser_d  = s_tuser[grant_q];
                    tlast_d  = s_tlast[grant_q];
                    tvalid_d = 1'b1;
`ifdef OUTPUT_P4_SRC_STAMP_EN
                    if (first_q) begin
                        tuser_d[SRC_STAMP_LSB +: GRANT_WIDTH] = grant_q;
                    end
                    first_d = 1'b0;
`endif
                    if (s_tlast[grant_q]) begin
                        last_grant_d = grant_q;
                        state_d      = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge axis_aclk) begin
        if (axis_reset) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= GRANT_WIDTH'(NUM_INPUTS - 1);
            tdata_q      <= '0;
            tkeep_q      <= '0;
            tuser_q      <= '0;
            tlast_q      <= 1'b0;
            tvalid_q     <= 1'b0;
`ifdef OUTPUT_P4_SRC_STAMP_EN
            first_q      <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            tdata_q      <= tdata_d;
            tkeep_q      <= tkeep_d;
            tuser_q      <= tuser_d;
            tlast_q      <= tlast_d;
            tvalid_q     <= tvalid_d;
`ifdef OUTPUT_P4_SRC_STAMP_EN
            first_q      <= first_d;
`endif
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tkeep  = tkeep_q;
    assign m_axis_tuser  = tuser_q;
    assign m_axis_tlast  = tlast_q;
    assign m_axis_tvalid = tvalid_q;

endmodule

// File: tb/tb_output_p4_interface.sv
// Scoreboard bench for output_p4_interface; expected beats are queued per input as stimulus is built.
module tb_output_p4_interface;

    typedef struct {
        logic [255:0] data;
        logic [31:0]  keep;
        logic [127:0] user;
        logic         last;
        int           gap;
    } beat_t;

    logic         clk;
    logic         rst;
    logic [255:0] s_tdata [4];
    logic [31:0]  s_tkeep [4];
    logic [127:0] s_tuser [4];
    logic         s_tvalid [4];
    logic         s_tlast [4];
    logic [3:0]   s_tready;
    logic [255:0] m_tdata;
    logic [31:0]  m_tkeep;
    logic [127:0] m_tuser;
    logic         m_tvalid;
    logic         m_tlast;
    logic         m_tready;

    beat_t send_q [4][$];
    beat_t exp_q [4][$];
    int    order_q [$];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int pkt_id = 0;
    int beats_seen = 0;
    int bad_tready = 0;
    int other_bad = 0;
    bit mon_en = 1'b0;
    bit in_pkt = 1'b0;
    bit have_last = 1'b0;
    bit gap_chk_en = 1'b0;
    bit chk_other = 1'b0;
    int cur_src = 0;
    int last_tlast_cyc = 0;

    output_p4_interface dut (
        .axis_aclk       (clk),
        .axis_reset      (rst),
        .s_axis_0_tdata  (s_tdata[0]),
        .s_axis_0_tkeep  (s_tkeep[0]),
        .s_axis_0_tuser  (s_tuser[0]),
        .s_axis_0_tvalid (s_tvalid[0]),
        .s_axis_0_tlast  (s_tlast[0]),
        .s_axis_0_tready (s_tready[0]),
        .s_axis_1_tdata  (s_tdata[1]),
        .s_axis_1_tkeep  (s_tkeep[1]),
        .s_axis_1_tuser  (s_tuser[1]),
        .s_axis_1_tvalid (s_tvalid[1]),
        .s_axis_1_tlast  (s_tlast[1]),
        .s_axis_1_tready (s_tready[1]),
        .s_axis_2_tdata  (s_tdata[2]),
        .s_axis_2_tkeep  (s_tkeep[2]),
        .s_axis_2_tuser  (s_tuser[2]),
        .s_axis_2_tvalid (s_tvalid[2]),
        .s_axis_2_tlast  (s_tlast[2]),
        .s_axis_2_tready (s_tready[2]),
        .s_axis_3_tdata  (s_tdata[3]),
        .s_axis_3_tkeep  (s_tkeep[3]),
        .s_axis_3_tuser  (s_tuser[3]),
        .s_axis_3_tvalid (s_tvalid[3]),
        .s_axis_3_tlast  (s_tlast[3]),
        .s_axis_3_tready (s_tready[3]),
        .m_axis_tdata    (m_tdata),
        .m_axis_tkeep    (m_tkeep),
        .m_axis_tuser    (m_tuser),
        .m_axis_tvalid   (m_tvalid),
        .m_axis_tlast    (m_tlast),
        .m_axis_tready   (m_tready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic send_pkt(input int src, input int nbeats, input logic [127:0] user,
                            input logic [127:0] user_rest, input int gap_idx, input int gap_len);
        beat_t b;
        pkt_id++;
        for (int i = 0; i < nbeats; i++) begin
            for (int w = 0; w < 8; w++) b.data[w*32 +: 32] = $urandom;
            b.data[255:240] = {4'(src), 4'(i), 8'(pkt_id)};
            b.keep = (i == nbeats - 1) ? 32'h0000_ffff : 32'hffff_ffff;
            b.user = (i == 0) ? user : (user | user_rest);
            b.last = (i == nbeats - 1);
            b.gap  = (i == gap_idx) ? gap_len : 0;
            send_q[src].push_back(b);
`ifdef OUTPUT_P4_SRC_STAMP_EN
            if (i == 0) b.user[33:32] = 2'(src);
`endif
            exp_q[src].push_back(b);
        end
        order_q.push_back(src);
    endtask

    task automatic flush_all();
        for (int i = 0; i < 4; i++) begin
            send_q[i].delete();
            exp_q[i].delete();
        end
        order_q.delete();
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        rst = 1'b1;
        mon_en = 1'b0;
        flush_all();
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        in_pkt = 1'b0;
        have_last = 1'b0;
        mon_en = 1'b1;
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int pending;
        pending = 1;
        for (int i = 0; i < budget && pending != 0; i++) begin
            @(posedge clk); #2;
            pending = order_q.size() + exp_q[0].size() + exp_q[1].size()
                    + exp_q[2].size() + exp_q[3].size() + int'(in_pkt) + int'(m_tvalid);
        end
        check(tag, pending, 0);
    endtask

    task automatic wait_beats(input string tag, input int target, input int budget);
        int i;
        for (i = 0; i < budget && beats_seen < target; i++) begin
            @(posedge clk); #2;
        end
        check(tag, beats_seen >= target, 1);
    endtask

    // Per-input source: holds a beat until the handshake, honouring per-beat idle gaps.
    for (genvar g = 0; g < 4; g++) begin : g_drv
        initial begin
            bit    took;
            beat_t b;
            s_tvalid[g] = 1'b0;
            s_tdata[g]  = '0;
            s_tkeep[g]  = '0;
            s_tuser[g]  = '0;
            s_tlast[g]  = 1'b0;
            forever begin
                @(negedge clk);
                took = s_tvalid[g] && s_tready[g];
                @(posedge clk); #1;
                if (took && send_q[g].size() > 0) void'(send_q[g].pop_front());
                if (send_q[g].size() > 0 && send_q[g][0].gap > 0) begin
                    b = send_q[g][0];
                    b.gap = b.gap - 1;
                    send_q[g][0] = b;
                    s_tvalid[g] = 1'b0;
                end else if (send_q[g].size() > 0) begin
                    b = send_q[g][0];
                    s_tdata[g]  = b.data;
                    s_tkeep[g]  = b.keep;
                    s_tuser[g]  = b.user;
                    s_tlast[g]  = b.last;
                    s_tvalid[g] = 1'b1;
                end else begin
                    s_tvalid[g] = 1'b0;
                end
            end
        end
    end

    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            if (!$onehot0(s_tready)) bad_tready++;
            if (chk_other && (s_tready & 4'b1011) != 4'b0000) other_bad++;
            if (mon_en && m_tvalid && m_tready) begin
                if (!in_pkt) begin
                    if (order_q.size() == 0) begin
                        check("unexpected_pkt", 1, 0);
                    end else begin
                        cur_src = order_q.pop_front();
                        in_pkt = 1'b1;
                        if (gap_chk_en && have_last) check("idle_gap", cyc - last_tlast_cyc, 2);
                    end
                end
                if (in_pkt) begin
                    if (exp_q[cur_src].size() == 0) begin
                        check("missing_beat", 1, 0);
                    end else begin
                        e = exp_q[cur_src].pop_front();
                        check("tdata", m_tdata, e.data);
                        check("tkeep", m_tkeep, e.keep);
                        check("tuser", m_tuser, e.user);
                        check("tlast", m_tlast, e.last);
                        beats_seen++;
                        if (e.last) begin
                            in_pkt = 1'b0;
                            have_last = 1'b1;
                            last_tlast_cyc = cyc;
                        end
                    end
                end
            end
        end
    end

    initial begin
        int t0;
        int t1;
        int base;
        int stall_bad;
        logic [255:0] snap_data;
        logic [127:0] snap_user;
        logic [31:0]  snap_keep;
        logic         snap_last;
        logic         snap_valid;

        rst = 1'b1;
        m_tready = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        check("rst_tvalid", m_tvalid, 0);
        check("rst_tlast", m_tlast, 0);
        check("rst_tdata", m_tdata, 0);
        check("rst_tkeep", m_tkeep, 0);
        check("rst_tuser", m_tuser, 0);
        check("rst_tready", s_tready, 0);
        mon_en = 1'b1;

        // Single 2-beat packet on input 2 with latency measurement.
        @(posedge clk); #2;
        chk_other = 1'b1;
        send_pkt(2, 2, 128'h0040_0040, 128'h0, -1, 0);
        t0 = -100;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (s_tvalid[2]) begin t0 = cyc; break; end
        end
        t1 = -200;
        for (int i = 0; i < 20; i++) begin
            if (m_tvalid) begin t1 = cyc; break; end
            @(negedge clk);
        end
        check("first_latency", t1 - t0, 2);
        wait_drain("drain_single", 50);
        chk_other = 1'b0;
        check("other_tready", other_bad, 0);

        // All four inputs continuously valid: grant order 0,1,2,3,0.
        do_reset();
        gap_chk_en = 1'b1;
        for (int s = 0; s < 4; s++) send_pkt(s, 3, 128'(32'h1000 + s), 128'h0, -1, 0);
        send_pkt(0, 3, 128'h2000, 128'h0, -1, 0);
        wait_drain("drain_rr", 200);
        gap_chk_en = 1'b0;

        // Input 1 stalls mid-packet while input 3 waits.
        send_pkt(1, 3, 128'h3001, 128'h0, 1, 5);
        repeat (2) @(posedge clk);
        #2;
        send_pkt(3, 2, 128'h3003, 128'h0, -1, 0);
        wait_drain("drain_gap", 100);

        // Downstream backpressure for 4 cycles mid-packet.
        base = beats_seen;
        send_pkt(0, 4, 128'h4000, 128'h0, -1, 0);
        wait_beats("stall_start", base + 1, 50);
        m_tready = 1'b0;
        stall_bad = 0;
        @(negedge clk);
        snap_data = m_tdata; snap_user = m_tuser; snap_keep = m_tkeep;
        snap_last = m_tlast; snap_valid = m_tvalid;
        if (s_tready != 4'b0000) stall_bad++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (m_tdata !== snap_data || m_tuser !== snap_user || m_tkeep !== snap_keep ||
                m_tlast !== snap_last || m_tvalid !== snap_valid) stall_bad++;
            if (s_tready != 4'b0000) stall_bad++;
        end
        check("stall_valid", snap_valid, 1);
        check("stall_stable", stall_bad, 0);
        @(posedge clk); #2;
        m_tready = 1'b1;
        wait_drain("drain_stall", 100);

        // Reset during beat 2 of a 4-beat packet on input 3, after input 0 last won.
        do_reset();
        send_pkt(0, 2, 128'h5000, 128'h0, -1, 0);
        wait_drain("drain_pre_rst", 50);
        base = beats_seen;
        send_pkt(3, 4, 128'h5003, 128'h0, -1, 0);
        wait_beats("rst_mid_start", base + 2, 50);
        rst = 1'b1;
        mon_en = 1'b0;
        flush_all();
        @(posedge clk); #2;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_tvalid", m_tvalid, 0);
        check("midrst_tready", s_tready, 0);
        check("midrst_tdata", m_tdata, 0);
        in_pkt = 1'b0;
        have_last = 1'b0;
        mon_en = 1'b1;
        send_pkt(0, 2, 128'h6000, 128'h0, -1, 0);
        send_pkt(1, 2, 128'h6001, 128'h0, -1, 0);
        wait_drain("drain_post_rst", 100);

        // Source stamp: beat 1 carries tuser[33:32]=01 from the source, beat 0 has 00.
        send_pkt(3, 2, 128'h0040_0040, 128'h1_0000_0000, -1, 0);
        wait_drain("drain_stamp", 50);

        check("tready_onehot", bad_tready, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
